// File: rtl/simon_round_ctrl.sv
// ---------------------------------------------------------------------------
// simon_round_ctrl
//
// Game-round controller for the note-memory game.
// - Builds an 8-note pattern from a seeded 16-bit Galois LFSR.
// - Plays a growing prefix of that pattern on the piezo/LED outputs, using
//   tone and gap timers.
// - Collects the player's key presses and checks them against the pattern.
// - Advances to the next round, or ends the game in WIN or LOSE.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   reset        asynchronous active-high reset, clears all state
//   start        begin a new game (accepted in IDLE, WIN and LOSE only)
//   seed[15:0]   LFSR seed, sampled when start is accepted (0 -> 16'hACE1)
//   key_valid    one-cycle strobe: the player pressed a key
//   key_code[3:0] pressed note, qualified by key_valid
//   piezo_out[3:0] note currently sounding (0 = silent)
//   led_out[3:0]   LED note display
//   pattern_out[31:0] generated pattern, nibble i = note i
//   round_len[3:0] notes in the current round (1..8, 0 before first GEN)
//   score[7:0]     completed rounds, saturating at 255
//   state_out[2:0] FSM state encoding
//   win / lose     high in WIN / LOSE respectively
// ---------------------------------------------------------------------------
module simon_round_ctrl #(
  parameter int NOTE_TICKS    = 4,
  parameter int GAP_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] seed,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [3:0]  piezo_out,
  output logic [3:0]  led_out,
  output logic [31:0] pattern_out,
  output logic [3:0]  round_len,
  output logic [7:0]  score,
  output logic [2:0]  state_out,
  output logic        win,
  output logic        lose
);

  localparam int TICK_MAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int TICK_W   = $clog2(TICK_MAX + 1);
  localparam int TO_W     = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [TICK_W-1:0] NOTE_LAST = TICK_W'(NOTE_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(GAP_TICKS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GEN    = 3'd1,
    TONE   = 3'd2,
    GAP    = 3'd3,
    LISTEN = 3'd4,
    WIN    = 3'd5,
    LOSE   = 3'd6
  } state_t;

  state_t             state_q,   state_d;
  logic [15:0]        lfsr_q,    lfsr_d;
  logic [31:0]        pattern_q, pattern_d;
  logic [2:0]         genIdx_q,  genIdx_d;
  logic [3:0]         playIdx_q, playIdx_d;
  logic [2:0]         ansIdx_q,  ansIdx_d;
  logic [3:0]         roundLen_q, roundLen_d;
  logic [7:0]         score_q,   score_d;
  logic [TICK_W-1:0]  tick_q,    tick_d;
  logic [TO_W-1:0]    timeout_q, timeout_d;
  logic [3:0]         lastKey_q, lastKey_d;
  logic               leadIn_q,  leadIn_d;

  logic [15:0]        lfsrNext;
  logic [3:0]         playNote;
  logic [3:0]         expectNote;

  function automatic logic [3:0] noteAt(input logic [31:0] pat, input logic [2:0] idx);
    return pat[{idx, 2'b00} +: 4];
  endfunction

  // Right-shifting Galois LFSR, taps 16'hB400; the new value feeds the note.
  assign lfsrNext   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign playNote   = noteAt(pattern_q, playIdx_q[2:0]);
  assign expectNote = noteAt(pattern_q, ansIdx_q);

  // State register and all datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      lfsr_q     <= 16'h0000;
      pattern_q  <= 32'h0000_0000;
      genIdx_q   <= 3'd0;
      playIdx_q  <= 4'd0;
      ansIdx_q   <= 3'd0;
      roundLen_q <= 4'd0;
      score_q    <= 8'd0;
      tick_q     <= '0;
      timeout_q  <= '0;
      lastKey_q  <= 4'd0;
      leadIn_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      pattern_q  <= pattern_d;
      genIdx_q   <= genIdx_d;
      playIdx_q  <= playIdx_d;
      ansIdx_q   <= ansIdx_d;
      roundLen_q <= roundLen_d;
      score_q    <= score_d;
      tick_q     <= tick_d;
      timeout_q  <= timeout_d;
      lastKey_q  <= lastKey_d;
      leadIn_q   <= leadIn_d;
    end
  end

  // Next-state logic for the game sequencer. Every register holds its
  // value unless the current state explicitly updates it.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    pattern_d  = pattern_q;
    genIdx_d   = genIdx_q;
    playIdx_d  = playIdx_q;
    ansIdx_d   = ansIdx_q;
    roundLen_d = roundLen_q;
    score_d    = score_q;
    tick_d     = tick_q;
    timeout_d  = timeout_q;
    lastKey_d  = lastKey_q;
    leadIn_d   = leadIn_q;

    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          lfsr_d    = (seed == 16'h0000) ? 16'hACE1 : seed;
          score_d   = 8'd0;
          pattern_d = 32'h0000_0000;
          genIdx_d  = 3'd0;
          state_d   = GEN;
        end
      end

      GEN: begin
        lfsr_d = lfsrNext;
        pattern_d[{genIdx_q, 2'b00} +: 4] = {1'b0, lfsrNext[2:0]} + 4'd1;
        genIdx_d = genIdx_q + 3'd1;
        if (genIdx_q == 3'd7) begin
          roundLen_d = 4'd1;
          playIdx_d  = 4'd0;
          tick_d     = '0;
          leadIn_d   = 1'b0;
          state_d    = TONE;
        end
      end

      TONE: begin
        if (tick_q == NOTE_LAST) begin
          tick_d  = '0;
          state_d = GAP;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      // The silent lead-in before a new round reuses GAP; when it ends the
      // playback starts from note 0 instead of advancing the index, so the
      // whole prefix is replayed.
      GAP: begin
        if (tick_q == GAP_LAST) begin
          tick_d = '0;
          if (leadIn_q) begin
            leadIn_d = 1'b0;
            state_d  = TONE;
          end else begin
            playIdx_d = playIdx_q + 4'd1;
            if ((playIdx_q + 4'd1) == roundLen_q) begin
              ansIdx_d  = 3'd0;
              timeout_d = '0;
              lastKey_d = 4'd0;
              state_d   = LISTEN;
            end else begin
              state_d = TONE;
            end
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      // A key strobe always wins over an expiring timeout in the same cycle.
      LISTEN: begin
        if (key_valid) begin
          lastKey_d = key_code;
          if (key_code == expectNote) begin
            if ({1'b0, ansIdx_q} == (roundLen_q - 4'd1)) begin
              score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
              if (roundLen_q == 4'd8) begin
                state_d = WIN;
              end else begin
                roundLen_d = roundLen_q + 4'd1;
                playIdx_d  = 4'd0;
                tick_d     = '0;
                leadIn_d   = 1'b1;
                state_d    = GAP;
              end
            end else begin
              ansIdx_d  = ansIdx_q + 3'd1;
              timeout_d = '0;
            end
          end else begin
            state_d = LOSE;
          end
        end else if (timeout_q == TO_LAST) begin
          state_d = LOSE;
        end else begin
          timeout_d = timeout_q + TO_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only.
  always_comb begin
    piezo_out = 4'd0;
    led_out   = 4'd0;
    if (state_q == TONE) begin
      piezo_out = playNote;
      led_out   = playNote;
    end else if (state_q == LISTEN) begin
      led_out = lastKey_q;
    end
  end

  assign pattern_out = pattern_q;
  assign round_len   = roundLen_q;
  assign score       = score_q;
  assign state_out   = state_q;
  assign win         = (state_q == WIN);
  assign lose        = (state_q == LOSE);

endmodule

// File: tb/tb_simon_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_simon_round_ctrl
//
// Directed testbench for simon_round_ctrl with default parameters.
// Inputs change on falling edges; outputs are sampled on falling edges.
// Patterns: seed 0 (-> 16'hACE1) gives notes 1,1,5,7,8,4,2,5 = 32'h52487511;
//           seed 16'h1234 gives notes 3,6,7,4,2,1,5,3 = 32'h35124763.
// ---------------------------------------------------------------------------
module tb_simon_round_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] seed;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [3:0]  piezo_out;
  logic [3:0]  led_out;
  logic [31:0] pattern_out;
  logic [3:0]  round_len;
  logic [7:0]  score;
  logic [2:0]  state_out;
  logic        win;
  logic        lose;

  int vecCount  = 0;
  int missCount = 0;

  localparam logic [31:0] PAT_ACE1 = 32'h5248_7511;
  localparam logic [31:0] PAT_1234 = 32'h3512_4763;

  simon_round_ctrl #(
    .NOTE_TICKS(4),
    .GAP_TICKS(2),
    .TIMEOUT_TICKS(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .seed(seed),
    .key_valid(key_valid),
    .key_code(key_code),
    .piezo_out(piezo_out),
    .led_out(led_out),
    .pattern_out(pattern_out),
    .round_len(round_len),
    .score(score),
    .state_out(state_out),
    .win(win),
    .lose(lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream hangs.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, vectors %0d", vecCount);
    $fatal(1, "[TB] watchdog expired");
  end

  // Polls state_out on falling edges until it matches or the budget runs out.
  task automatic waitState(input logic [2:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (state_out === target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulseStart(input logic [15:0] s);
    start = 1'b1;
    seed  = s;
    @(negedge clk);
    start = 1'b0;
    seed  = 16'h0000;
  endtask

  // Presses the first n notes of pat in consecutive cycles.
  task automatic enterKeys(input logic [31:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      key_valid = 1'b1;
      key_code  = pat[4*i +: 4];
      @(negedge clk);
    end
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    start     = 1'b0;
    seed      = 16'h0000;
    key_valid = 1'b0;
    key_code  = 4'd0;
    repeat (3) @(negedge clk);
    vecCount++;
    if (state_out !== 3'd0) begin
      missCount++;
      $display("[TB] FAIL reset_state: got %0d expected 0", state_out);
    end
    vecCount++;
    if ({piezo_out, led_out, round_len, score} !== 20'h0) begin
      missCount++;
      $display("[TB] FAIL reset_outputs: piezo %0d led %0d round_len %0d score %0d expected all 0",
               piezo_out, led_out, round_len, score);
    end
    vecCount++;
    if (pattern_out !== 32'h0 || win !== 1'b0 || lose !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL reset_pattern_flags: pattern %h win %b lose %b expected 0/0/0",
               pattern_out, win, lose);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_round;
    pulseStart(16'h0000);
    vecCount++;
    if (state_out !== 3'd1 || pattern_out !== 32'h0 || score !== 8'd0) begin
      missCount++;
      $display("[TB] FAIL gen_entry: state %0d pattern %h score %0d expected 1/00000000/0",
               state_out, pattern_out, score);
    end
    repeat (8) @(negedge clk);
    vecCount++;
    if (pattern_out !== PAT_ACE1) begin
      missCount++;
      $display("[TB] FAIL gen_pattern: got %h expected %h", pattern_out, PAT_ACE1);
    end
    vecCount++;
    if (state_out !== 3'd2 || round_len !== 4'd1) begin
      missCount++;
      $display("[TB] FAIL gen_done: state %0d round_len %0d expected 2/1", state_out, round_len);
    end
    for (int i = 0; i < 4; i++) begin
      vecCount++;
      if (state_out !== 3'd2 || piezo_out !== 4'd1 || led_out !== 4'd1) begin
        missCount++;
        $display("[TB] FAIL tone_cycle%0d: state %0d piezo %0d led %0d expected 2/1/1",
                 i, state_out, piezo_out, led_out);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      vecCount++;
      if (state_out !== 3'd3 || piezo_out !== 4'd0 || led_out !== 4'd0) begin
        missCount++;
        $display("[TB] FAIL gap_cycle%0d: state %0d piezo %0d led %0d expected 3/0/0",
                 i, state_out, piezo_out, led_out);
      end
      @(negedge clk);
    end
    vecCount++;
    if (state_out !== 3'd4 || piezo_out !== 4'd0 || led_out !== 4'd0) begin
      missCount++;
      $display("[TB] FAIL listen_entry: state %0d piezo %0d led %0d expected 4/0/0",
               state_out, piezo_out, led_out);
    end
    enterKeys(PAT_ACE1, 1);
    vecCount++;
    if (score !== 8'd1 || round_len !== 4'd2 || state_out !== 3'd3) begin
      missCount++;
      $display("[TB] FAIL round1_advance: score %0d round_len %0d state %0d expected 1/2/3",
               score, round_len, state_out);
    end
  endtask

  task automatic test_win;
    bit ok;
    for (int r = 2; r <= 8; r++) begin
      waitState(3'd4, 200, ok);
      vecCount++;
      if (!ok) begin
        missCount++;
        $display("[TB] FAIL win_wait_listen_r%0d: state %0d expected 4 within 200 cycles", r, state_out);
      end
      enterKeys(PAT_ACE1, r);
      vecCount++;
      if (score !== 8'(r)) begin
        missCount++;
        $display("[TB] FAIL win_score_r%0d: got %0d expected %0d", r, score, r);
      end
      if (r < 8) begin
        vecCount++;
        if (state_out !== 3'd3 || round_len !== 4'(r + 1)) begin
          missCount++;
          $display("[TB] FAIL win_next_round_r%0d: state %0d round_len %0d expected 3/%0d",
                   r, state_out, round_len, r + 1);
        end
      end
    end
    vecCount++;
    if (state_out !== 3'd5 || win !== 1'b1 || lose !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL win_final: state %0d win %b lose %b expected 5/1/0", state_out, win, lose);
    end
  endtask

  task automatic test_wrong_key;
    bit ok;
    pulseStart(16'h0000);
    vecCount++;
    if (state_out !== 3'd1 || score !== 8'd0) begin
      missCount++;
      $display("[TB] FAIL restart_from_win: state %0d score %0d expected 1/0", state_out, score);
    end
    for (int r = 1; r <= 2; r++) begin
      waitState(3'd4, 200, ok);
      vecCount++;
      if (!ok) begin
        missCount++;
        $display("[TB] FAIL wrong_wait_listen_r%0d: state %0d expected 4", r, state_out);
      end
      enterKeys(PAT_ACE1, r);
    end
    waitState(3'd4, 200, ok);
    vecCount++;
    if (!ok) begin
      missCount++;
      $display("[TB] FAIL wrong_wait_listen_r3: state %0d expected 4", state_out);
    end
    key_valid = 1'b1;
    key_code  = 4'd1;
    @(negedge clk);
    vecCount++;
    if (state_out !== 3'd4 || led_out !== 4'd1) begin
      missCount++;
      $display("[TB] FAIL wrong_first_key: state %0d led %0d expected 4/1", state_out, led_out);
    end
    key_code = 4'd1;
    @(negedge clk);
    key_code = 4'd4;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
    vecCount++;
    if (state_out !== 3'd6 || lose !== 1'b1 || win !== 1'b0 || score !== 8'd2) begin
      missCount++;
      $display("[TB] FAIL wrong_key_lose: state %0d lose %b win %b score %0d expected 6/1/0/2",
               state_out, lose, win, score);
    end
  endtask

  task automatic test_reseed;
    pulseStart(16'h1234);
    vecCount++;
    if (state_out !== 3'd1 || score !== 8'd0 || pattern_out !== 32'h0) begin
      missCount++;
      $display("[TB] FAIL reseed_entry: state %0d score %0d pattern %h expected 1/0/00000000",
               state_out, score, pattern_out);
    end
    repeat (8) @(negedge clk);
    vecCount++;
    if (pattern_out !== PAT_1234) begin
      missCount++;
      $display("[TB] FAIL reseed_pattern: got %h expected %h", pattern_out, PAT_1234);
    end
    vecCount++;
    if (state_out !== 3'd2 || round_len !== 4'd1 || piezo_out !== 4'd3) begin
      missCount++;
      $display("[TB] FAIL reseed_tone: state %0d round_len %0d piezo %0d expected 2/1/3",
               state_out, round_len, piezo_out);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    waitState(3'd4, 200, ok);
    vecCount++;
    if (!ok) begin
      missCount++;
      $display("[TB] FAIL timeout_wait_listen: state %0d expected 4", state_out);
    end
    repeat (63) @(negedge clk);
    vecCount++;
    if (state_out !== 3'd4 || lose !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL timeout_cycle63: state %0d lose %b expected 4/0", state_out, lose);
    end
    @(negedge clk);
    vecCount++;
    if (state_out !== 3'd6 || lose !== 1'b1 || win !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL timeout_lose: state %0d lose %b win %b expected 6/1/0", state_out, lose, win);
    end
    pulseStart(16'h0000);
    waitState(3'd4, 200, ok);
    vecCount++;
    if (!ok) begin
      missCount++;
      $display("[TB] FAIL timeout_wait_listen2: state %0d expected 4", state_out);
    end
    repeat (63) @(negedge clk);
    enterKeys(PAT_ACE1, 1);
    vecCount++;
    if (state_out !== 3'd3 || lose !== 1'b0 || score !== 8'd1) begin
      missCount++;
      $display("[TB] FAIL timeout_key_priority: state %0d lose %b score %0d expected 3/0/1",
               state_out, lose, score);
    end
  endtask

  task automatic test_ignore_and_reset;
    bit ok;
    key_valid = 1'b1;
    key_code  = 4'd9;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
    vecCount++;
    if (state_out !== 3'd3 || lose !== 1'b0 || score !== 8'd1) begin
      missCount++;
      $display("[TB] FAIL key_in_gap_ignored: state %0d lose %b score %0d expected 3/0/1",
               state_out, lose, score);
    end
    waitState(3'd2, 100, ok);
    vecCount++;
    if (!ok) begin
      missCount++;
      $display("[TB] FAIL ignore_wait_tone: state %0d expected 2", state_out);
    end
    pulseStart(16'h1234);
    vecCount++;
    if (state_out !== 3'd2 || pattern_out !== PAT_ACE1 || score !== 8'd1) begin
      missCount++;
      $display("[TB] FAIL start_in_tone_ignored: state %0d pattern %h score %0d expected 2/%h/1",
               state_out, pattern_out, score, PAT_ACE1);
    end
    waitState(3'd4, 200, ok);
    vecCount++;
    if (!ok) begin
      missCount++;
      $display("[TB] FAIL ignore_wait_listen: state %0d expected 4", state_out);
    end
    pulseStart(16'h1234);
    vecCount++;
    if (state_out !== 3'd4 || pattern_out !== PAT_ACE1 || round_len !== 4'd2) begin
      missCount++;
      $display("[TB] FAIL start_in_listen_ignored: state %0d pattern %h round_len %0d expected 4/%h/2",
               state_out, pattern_out, round_len, PAT_ACE1);
    end
    enterKeys(PAT_ACE1, 2);
    waitState(3'd2, 100, ok);
    vecCount++;
    if (!ok || score !== 8'd2) begin
      missCount++;
      $display("[TB] FAIL reset_setup: state %0d score %0d expected 2/2", state_out, score);
    end
    #2;
    reset = 1'b1;
    #1;
    vecCount++;
    if (state_out !== 3'd0 || piezo_out !== 4'd0 || led_out !== 4'd0) begin
      missCount++;
      $display("[TB] FAIL async_reset_state: state %0d piezo %0d led %0d expected 0/0/0",
               state_out, piezo_out, led_out);
    end
    vecCount++;
    if (pattern_out !== 32'h0 || round_len !== 4'd0 || score !== 8'd0 || win !== 1'b0 || lose !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL async_reset_regs: pattern %h round_len %0d score %0d win %b lose %b expected all 0",
               pattern_out, round_len, score, win, lose);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vecCount++;
    if (state_out !== 3'd0) begin
      missCount++;
      $display("[TB] FAIL idle_after_reset: state %0d expected 0", state_out);
    end
  endtask

  initial begin
    test_reset;
    test_first_round;
    test_win;
    test_wrong_key;
    test_reseed;
    test_timeout;
    test_ignore_and_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
